axi_lite_sram_slave: RTL and testbench
======================================

AXI_LITE_SRAM_SLAVE -- requirements
Module: axi_lite_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width in bits, legal values 32 or 64.
REQ-003 SHALL have parameter MEM_DEPTH, default 256: number of DATA_WIDTH words, power of two.
REQ-004 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports S_AXI_AWADDR in ADDR_WIDTH, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write address channel.
REQ-007 SHALL have ports S_AXI_WDATA in DATA_WIDTH, S_AXI_WSTRB in DATA_WIDTH/8, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write data channel.
REQ-008 SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response channel.
REQ-009 SHALL have ports S_AXI_ARADDR in ADDR_WIDTH, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address channel.
REQ-010 SHALL have ports S_AXI_RDATA out DATA_WIDTH, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data channel.

Function
REQ-011 SHALL define LSB = log2(DATA_WIDTH/8), IDX = log2(MEM_DEPTH), word index = addr[LSB+IDX-1:LSB]; address bits below LSB are ignored.
REQ-012 SHALL treat an address as out-of-range when any bit above LSB+IDX-1 is 1.
REQ-013 SHALL hold AW and W in independent one-entry registers (aw_full, w_full), each accepting in any order or in the same cycle.
REQ-014 SHALL drive S_AXI_AWREADY = !aw_full and S_AXI_WREADY = !w_full.
REQ-015 SHALL commit a write on the first rising edge where aw_full && w_full && !S_AXI_BVALID; on that edge clear aw_full and w_full, and set S_AXI_BVALID.
REQ-016 SHALL on commit update byte lane k of the indexed word only when WSTRB[k] = 1 and the address is in range; other lanes keep their value.
REQ-017 SHALL return BRESP 2'b00 (OKAY) for in-range writes and 2'b10 (SLVERR) for out-of-range writes; an out-of-range write changes no memory.
REQ-018 SHALL hold BVALID and BRESP stable until the BVALID && BREADY edge, then clear BVALID; no further commit may occur while BVALID is high.
REQ-019 SHALL drive S_AXI_ARREADY = !S_AXI_RVALID.
REQ-020 SHALL on the AR handshake edge set RVALID, load RDATA with the indexed word (or 0 when out of range), and load RRESP with 2'b00 or 2'b10.
REQ-021 SHALL hold RDATA and RRESP stable while RVALID && !RREADY, and clear RVALID on the RVALID && RREADY edge.
REQ-022 SHALL make a read and a write commit to the same word on the same edge return pre-write data; the next read returns post-write data.
REQ-023 SHALL operate the read and write paths fully independently, each with no combinational path from any input to any READY or VALID output.
REQ-024 SHALL give minimum latencies of AW+W handshake edge N -> BVALID set at edge N+1, and AR handshake edge N -> RVALID set at edge N.

Reset
REQ-025 SHALL on rstn low clear aw_full, w_full, BVALID and RVALID, and set BRESP, RRESP and RDATA to 0; AWREADY, WREADY and ARREADY are therefore 1.
REQ-026 SHALL leave memory contents unchanged by reset; an uncommitted held AW or W is discarded.

Verification
REQ-027 SHALL cover: write 0x10 <- 0xDEADBEEF with WSTRB=0xF, then read 0x10 -> RDATA=0xDEADBEEF, RRESP=00, BRESP=00.
REQ-028 SHALL cover: after REQ-027, write 0x10 <- 0x11223344 with WSTRB=0x5 -> read returns 0xDE22BE44.
REQ-029 SHALL cover: W presented 3 cycles before AW -> WREADY low after W is held, commit one edge after AW is accepted, single BVALID pulse.
REQ-030 SHALL cover: with the default MEM_DEPTH=256, write and read to 0x400 -> BRESP=10, RRESP=10, RDATA=0, word 0 unchanged.
REQ-031 SHALL cover: BREADY held low 5 cycles -> BVALID and BRESP stable, AWREADY low after the next AW is accepted, and no second commit.
REQ-032 SHALL cover: rstn asserted with AW held and BVALID high -> after reset all VALIDs are 0, all READYs are 1, and previously written data is still readable.

Source files
------------

// File: rtl/axi_lite_sram_if.sv
// AXI4-Lite bus bundle between a master and the SRAM slave.
// Signal names follow the standard S_AXI_* channel naming.
interface axi_lite_sram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave backed by a byte-strobed word memory.
// AW and W are buffered independently; reads complete on the AR handshake edge.
module axi_lite_sram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input logic            clk,
  input logic            rstn,
  axi_lite_sram_if.slave s
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX    = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  aw_full;
  logic                  w_full;
  logic                  bvalid;
  logic [1:0]            bresp;
  logic [IDX-1:0]        aw_idx;
  logic                  aw_oor;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  rvalid;
  logic [1:0]            rresp;
  logic [DATA_WIDTH-1:0] rdata;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic                  ar_hs;
  logic                  aw_oor_in;
  logic                  ar_oor_in;
  logic [IDX-1:0]        ar_idx_in;

  assign aw_hs     = s.S_AXI_AWVALID && !aw_full;
  assign w_hs      = s.S_AXI_WVALID && !w_full;
  assign commit    = aw_full && w_full && !bvalid;
  assign ar_hs     = s.S_AXI_ARVALID && !rvalid;
  // Any set bit above the word-index field puts the access outside the array.
  assign aw_oor_in = (s.S_AXI_AWADDR >> (LSB + IDX)) != '0;
  assign ar_oor_in = (s.S_AXI_ARADDR >> (LSB + IDX)) != '0;
  assign ar_idx_in = s.S_AXI_ARADDR[LSB+IDX-1:LSB];

  assign s.S_AXI_AWREADY = !aw_full;
  assign s.S_AXI_WREADY  = !w_full;
  assign s.S_AXI_BVALID  = bvalid;
  assign s.S_AXI_BRESP   = bresp;
  assign s.S_AXI_ARREADY = !rvalid;
  assign s.S_AXI_RVALID  = rvalid;
  assign s.S_AXI_RRESP   = rresp;
  assign s.S_AXI_RDATA   = rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= aw_oor ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (aw_hs) aw_full <= 1'b1;
        if (w_hs)  w_full  <= 1'b1;
        if (bvalid && s.S_AXI_BREADY) bvalid <= 1'b0;
      end
    end
  end

  // Holding registers and the array carry no reset: contents survive rstn.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      aw_idx <= s.S_AXI_AWADDR[LSB+IDX-1:LSB];
      aw_oor <= aw_oor_in;
    end
    if (w_hs) begin
      w_data <= s.S_AXI_WDATA;
      w_strb <= s.S_AXI_WSTRB;
    end
    if (commit && !aw_oor) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (w_strb[k]) mem[aw_idx][8*k +: 8] <= w_data[8*k +: 8];
      end
    end
  end

  // Read samples the array with the pre-edge contents, so a same-edge commit is not seen.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid <= 1'b0;
      rresp  <= RESP_OKAY;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rresp  <= ar_oor_in ? RESP_SLVERR : RESP_OKAY;
      rdata  <= ar_oor_in ? '0 : mem[ar_idx_in];
    end else if (rvalid && s.S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Bench for axi_lite_sram_slave: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
`define CHK(n, a, e) chk(n, 64'(a), 64'(e))

module tb_axi_lite_sram_slave;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_lite_sram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256)) dut (
    .clk  (clk),
    .rstn (rstn),
    .s    (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit oor(input logic [31:0] a);
    return a[31:10] != 22'd0;
  endfunction

  // Model: memory image, pending AW/W queues, outstanding B and R beats.
  logic [31:0] mmem [256];
  logic [31:0] aq [$];
  logic [35:0] wq [$];
  bit          m_bv, m_rv;
  logic [1:0]  m_br, m_rr;
  logic [31:0] m_rd;
  bit          aw_acc, w_acc, ar_acc, m_commit;
  logic [31:0] ma;
  logic [35:0] mw;

  always @(negedge clk) begin
    if (!rstn) begin
      aq.delete();
      wq.delete();
      m_bv = 0; m_rv = 0; m_br = 0; m_rr = 0; m_rd = 0;
      `CHK("rst_awready", bus.S_AXI_AWREADY, 1);
      `CHK("rst_wready",  bus.S_AXI_WREADY, 1);
      `CHK("rst_arready", bus.S_AXI_ARREADY, 1);
      `CHK("rst_bvalid",  bus.S_AXI_BVALID, 0);
      `CHK("rst_rvalid",  bus.S_AXI_RVALID, 0);
      `CHK("rst_bresp",   bus.S_AXI_BRESP, 0);
      `CHK("rst_rresp",   bus.S_AXI_RRESP, 0);
      `CHK("rst_rdata",   bus.S_AXI_RDATA, 0);
    end else begin
      total++;
      if (bus.S_AXI_BVALID !== 1'(m_bv)) begin
        bad++;
        $display("FAIL model_bvalid: got %0b expected %0b at %0t", bus.S_AXI_BVALID, m_bv, $time);
      end
      total++;
      if (bus.S_AXI_RVALID !== 1'(m_rv)) begin
        bad++;
        $display("FAIL model_rvalid: got %0b expected %0b at %0t", bus.S_AXI_RVALID, m_rv, $time);
      end
      total++;
      if (bus.S_AXI_AWREADY !== 1'(aq.size() == 0)) begin
        bad++;
        $display("FAIL model_awready: got %0b expected %0b at %0t", bus.S_AXI_AWREADY, aq.size() == 0, $time);
      end
      `CHK("awready", bus.S_AXI_AWREADY, aq.size() == 0);
      `CHK("wready",  bus.S_AXI_WREADY, wq.size() == 0);
      `CHK("bvalid",  bus.S_AXI_BVALID, m_bv);
      `CHK("arready", bus.S_AXI_ARREADY, !m_rv);
      `CHK("rvalid",  bus.S_AXI_RVALID, m_rv);
      if (m_bv) `CHK("bresp", bus.S_AXI_BRESP, m_br);
      if (m_rv) begin
        `CHK("rdata", bus.S_AXI_RDATA, m_rd);
        `CHK("rresp", bus.S_AXI_RRESP, m_rr);
      end
      // Advance the model across the coming rising edge.
      aw_acc   = bus.S_AXI_AWVALID && aq.size() == 0;
      w_acc    = bus.S_AXI_WVALID && wq.size() == 0;
      ar_acc   = bus.S_AXI_ARVALID && !m_rv;
      m_commit = aq.size() != 0 && wq.size() != 0 && !m_bv;
      if (ar_acc) begin
        m_rv = 1;
        m_rd = oor(bus.S_AXI_ARADDR) ? 32'd0 : mmem[bus.S_AXI_ARADDR[9:2]];
        m_rr = oor(bus.S_AXI_ARADDR) ? 2'b10 : 2'b00;
      end else if (m_rv && bus.S_AXI_RREADY) begin
        m_rv = 0;
      end
      if (m_commit) begin
        ma = aq.pop_front();
        mw = wq.pop_front();
        m_bv = 1;
        m_br = oor(ma) ? 2'b10 : 2'b00;
        if (!oor(ma))
          for (int k = 0; k < 4; k++)
            if (mw[32+k]) mmem[ma[9:2]][8*k +: 8] = mw[8*k +: 8];
      end else if (m_bv && bus.S_AXI_BREADY) begin
        m_bv = 0;
      end
      if (aw_acc) aq.push_back(bus.S_AXI_AWADDR);
      if (w_acc)  wq.push_back({bus.S_AXI_WSTRB, bus.S_AXI_WDATA});
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                    output logic [1:0] resp);
    bit awd = 0, wd = 0, got = 0;
    bus.S_AXI_AWADDR = a; bus.S_AXI_AWVALID = 1;
    bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = st; bus.S_AXI_WVALID = 1;
    bus.S_AXI_BREADY = 1;
    resp = 2'b11;
    for (int n = 0; n < 20 && !(awd && wd); n++) begin
      @(negedge clk);
      if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) awd = 1;
      if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) wd = 1;
      @(posedge clk); #1;
      if (awd) bus.S_AXI_AWVALID = 0;
      if (wd) bus.S_AXI_WVALID = 0;
    end
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (bus.S_AXI_BVALID) begin got = 1; resp = bus.S_AXI_BRESP; end
    end
    `CHK("wr_bvalid_seen", got, 1);
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    bit acc = 0, got = 0;
    bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1; bus.S_AXI_RREADY = 1;
    d = 32'hFFFF_FFFF; r = 2'b11;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = bus.S_AXI_ARREADY;
      @(posedge clk); #1;
    end
    bus.S_AXI_ARVALID = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (bus.S_AXI_RVALID) begin got = 1; d = bus.S_AXI_RDATA; r = bus.S_AXI_RRESP; end
    end
    `CHK("rd_rvalid_seen", got, 1);
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
    if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(10, 31));
    return a;
  endfunction

  task automatic wait_bvalid(output bit got);
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = bus.S_AXI_BVALID;
    end
    `CHK("bvalid_seen", got, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r, rr, br0;
    logic [31:0] d;
    bit          got, awh, wh, arh;

    bus.S_AXI_AWADDR = 0; bus.S_AXI_AWVALID = 0;
    bus.S_AXI_WDATA = 0; bus.S_AXI_WSTRB = 0; bus.S_AXI_WVALID = 0;
    bus.S_AXI_BREADY = 0;
    bus.S_AXI_ARADDR = 0; bus.S_AXI_ARVALID = 0; bus.S_AXI_RREADY = 0;

    @(negedge clk);
    `CHK("init_awready", bus.S_AXI_AWREADY, 1);
    `CHK("init_bvalid", bus.S_AXI_BVALID, 0);
    @(posedge clk); #1;
    rstn = 1;

    for (int i = 0; i < 32; i++) wr(i * 4, $urandom, 4'hF, r);
    wr(32'h0, 32'hCAFE_F00D, 4'hF, r);

    wr(32'h10, 32'hDEAD_BEEF, 4'hF, r);
    `CHK("full_wr_bresp", r, 2'b00);
    rd(32'h10, d, rr);
    `CHK("full_rd_data", d, 32'hDEAD_BEEF);
    `CHK("full_rd_rresp", rr, 2'b00);
    total++;
    if (d !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL full_rd_data_direct: got %0h expected %0h at %0t", d, 32'hDEAD_BEEF, $time);
    end

    wr(32'h10, 32'h1122_3344, 4'h5, r);
    rd(32'h10, d, rr);
    `CHK("strb5_rd_data", d, 32'hDE22_BE44);
    total++;
    if (d !== 32'hDE22_BE44) begin
      bad++;
      $display("FAIL strb5_rd_data_direct: got %0h expected %0h at %0t", d, 32'hDE22_BE44, $time);
    end

    // W ahead of AW by three cycles.
    bus.S_AXI_WDATA = 32'h600D_F00D; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1;
    bus.S_AXI_BREADY = 1;
    @(negedge clk);
    `CHK("wfirst_wready", bus.S_AXI_WREADY, 1);
    @(posedge clk); #1;
    bus.S_AXI_WVALID = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      `CHK("wheld_wready", bus.S_AXI_WREADY, 0);
      `CHK("wheld_bvalid", bus.S_AXI_BVALID, 0);
      @(posedge clk); #1;
    end
    bus.S_AXI_AWADDR = 32'h20; bus.S_AXI_AWVALID = 1;
    @(negedge clk);
    `CHK("wfirst_awready", bus.S_AXI_AWREADY, 1);
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 0;
    @(negedge clk);
    `CHK("wfirst_bvalid_n", bus.S_AXI_BVALID, 0);
    @(negedge clk);
    `CHK("wfirst_bvalid_n1", bus.S_AXI_BVALID, 1);
    `CHK("wfirst_bresp", bus.S_AXI_BRESP, 2'b00);
    @(negedge clk);
    `CHK("wfirst_bvalid_pulse", bus.S_AXI_BVALID, 0);
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 0;
    rd(32'h20, d, rr);
    `CHK("wfirst_rd_data", d, 32'h600D_F00D);

    wr(32'h400, 32'h1234_5678, 4'hF, r);
    `CHK("oor_bresp", r, 2'b10);
    rd(32'h400, d, rr);
    `CHK("oor_rdata", d, 0);
    `CHK("oor_rresp", rr, 2'b10);
    rd(32'h0, d, rr);
    `CHK("oor_word0_kept", d, 32'hCAFE_F00D);

    // Backpressured response with a second write queued behind it.
    bus.S_AXI_AWADDR = 32'h800; bus.S_AXI_AWVALID = 1;
    bus.S_AXI_WDATA = 32'h5555_5555; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
    wait_bvalid(got);
    br0 = bus.S_AXI_BRESP;
    `CHK("bp_bresp_first", br0, 2'b10);
    @(posedge clk); #1;
    bus.S_AXI_AWADDR = 32'h34; bus.S_AXI_AWVALID = 1;
    bus.S_AXI_WDATA = 32'hA5A5_F00F; bus.S_AXI_WVALID = 1;
    @(negedge clk);
    `CHK("bp_awready_before", bus.S_AXI_AWREADY, 1);
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      `CHK("bp_bvalid_hold", bus.S_AXI_BVALID, 1);
      `CHK("bp_bresp_hold", bus.S_AXI_BRESP, br0);
      `CHK("bp_awready_low", bus.S_AXI_AWREADY, 0);
      `CHK("bp_wready_low", bus.S_AXI_WREADY, 0);
    end
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1;
    @(negedge clk);
    @(negedge clk);
    `CHK("bp_bvalid_gap", bus.S_AXI_BVALID, 0);
    @(negedge clk);
    `CHK("bp_second_bvalid", bus.S_AXI_BVALID, 1);
    `CHK("bp_second_bresp", bus.S_AXI_BRESP, 2'b00);
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 0;
    rd(32'h34, d, rr);
    `CHK("bp_rd_second", d, 32'hA5A5_F00F);

    // Reset with an unacknowledged response and a held AW.
    bus.S_AXI_AWADDR = 32'h40; bus.S_AXI_AWVALID = 1;
    bus.S_AXI_WDATA = 32'h0BAD_CAFE; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
    wait_bvalid(got);
    @(posedge clk); #1;
    bus.S_AXI_AWADDR = 32'h44; bus.S_AXI_AWVALID = 1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 0;
    @(negedge clk);
    `CHK("rst_pre_aw_held", bus.S_AXI_AWREADY, 0);
    @(posedge clk); #1;
    rstn = 0;
    #2;
    `CHK("rst_async_bvalid", bus.S_AXI_BVALID, 0);
    `CHK("rst_async_awready", bus.S_AXI_AWREADY, 1);
    @(posedge clk); #1;
    rstn = 1;
    bus.S_AXI_WDATA = 32'h7777_7777; bus.S_AXI_WVALID = 1; bus.S_AXI_BREADY = 1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.S_AXI_WVALID = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      `CHK("rst_aw_discarded", bus.S_AXI_BVALID, 0);
    end
    bus.S_AXI_AWADDR = 32'h44; bus.S_AXI_AWVALID = 1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 0;
    wait_bvalid(got);
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 0;
    rd(32'h40, d, rr);
    `CHK("rst_mem_kept_40", d, 32'h0BAD_CAFE);
    rd(32'h10, d, rr);
    `CHK("rst_mem_kept_10", d, 32'hDE22_BE44);
    rd(32'h44, d, rr);
    `CHK("rst_post_write_44", d, 32'h7777_7777);

    // Randomized traffic; the model process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      awh = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      wh  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      arh = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
      @(posedge clk); #1;
      if (!bus.S_AXI_AWVALID || awh) begin
        bus.S_AXI_AWVALID = $urandom_range(0, 2) != 0;
        bus.S_AXI_AWADDR = rand_addr();
      end
      if (!bus.S_AXI_WVALID || wh) begin
        bus.S_AXI_WVALID = $urandom_range(0, 2) != 0;
        bus.S_AXI_WDATA = $urandom;
        bus.S_AXI_WSTRB = 4'($urandom_range(0, 15));
      end
      if (!bus.S_AXI_ARVALID || arh) begin
        bus.S_AXI_ARVALID = $urandom_range(0, 2) != 0;
        bus.S_AXI_ARADDR = rand_addr();
      end
      bus.S_AXI_BREADY = $urandom_range(0, 3) != 0;
      bus.S_AXI_RREADY = $urandom_range(0, 3) != 0;
    end
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_ARVALID = 0;
    bus.S_AXI_BREADY = 1; bus.S_AXI_RREADY = 1;
    repeat (10) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
